// File: rtl/fire_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fire_seq_pkg
// Brief    : Shared geometry, widths and types for the fire expand sequencers.
// Revision : 1.0
// ============================================================================
package fire_seq_pkg;

  localparam int W_IN       = 8;
  localparam int CHIN       = 112;
  localparam int KERNEL_DIM = 3;
  localparam int STRIDE     = 1;
  localparam int PAD        = 1;
  localparam int MEM_LAT    = 1;
  localparam int W_OUT      = (W_IN + 2*PAD - KERNEL_DIM)/STRIDE + 1;

  localparam int IFM_AW = $clog2(W_IN*W_IN*CHIN);
  localparam int WGT_AW = $clog2(CHIN*KERNEL_DIM*KERNEL_DIM);
  localparam int PIX_AW = $clog2(W_OUT*W_OUT);
  localparam int OXY_W  = (W_OUT > 1) ? $clog2(W_OUT) : 1;
  localparam int KC_W   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int CH_W   = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int DRN_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic signed [15:0] coord_t;

  function automatic logic in_bounds(input coord_t v);
    return (v >= 16'sd0) && (v < coord_t'(W_IN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fire_ex3_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fire_ex3_seq_if
// Brief    : Control, memory-address and output handshake bundle of the
//            3x3 sequencer. FIRE_SEQ_PERF_EN adds the performance counters.
// Revision : 1.0
// ============================================================================
interface fire_ex3_seq_if;
  import fire_seq_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [IFM_AW-1:0] ifm_addr;
  logic              ifm_rd_en;
  logic [WGT_AW-1:0] wgt_addr;
  logic              pad_zero;
  logic              mac_en;
  logic              mac_first;
  logic              ofm_valid;
  logic              ofm_ready;
  logic [PIX_AW-1:0] ofm_pix;
`ifdef FIRE_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_stall;

  modport master (
    output start, ofm_ready,
    input  busy, done, ifm_addr, ifm_rd_en, wgt_addr, pad_zero,
    input  mac_en, mac_first, ofm_valid, ofm_pix, perf_cycles, perf_stall
  );
  modport slave (
    input  start, ofm_ready,
    output busy, done, ifm_addr, ifm_rd_en, wgt_addr, pad_zero,
    output mac_en, mac_first, ofm_valid, ofm_pix, perf_cycles, perf_stall
  );
`else
  modport master (
    output start, ofm_ready,
    input  busy, done, ifm_addr, ifm_rd_en, wgt_addr, pad_zero,
    input  mac_en, mac_first, ofm_valid, ofm_pix
  );
  modport slave (
    input  start, ofm_ready,
    output busy, done, ifm_addr, ifm_rd_en, wgt_addr, pad_zero,
    output mac_en, mac_first, ofm_valid, ofm_pix
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fire_tap_counter.sv
`default_nettype none
// ============================================================================
// Module   : fire_tap_counter
// Brief    : Nested kx / ky / channel counter (kx fastest); wraps to zero
//            after the last tap so each pixel restarts at tap 0.
// Revision : 1.0
// ============================================================================
module fire_tap_counter #(
  parameter int K  = 3,
  parameter int CH = 112,
  parameter int KW = (K > 1) ? $clog2(K) : 1,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_advance,
  output logic [KW-1:0] o_kx,
  output logic [KW-1:0] o_ky,
  output logic [CW-1:0] o_c,
  output logic          o_first_tap,
  output logic          o_last_tap
);

  logic [KW-1:0] r_kx;
  logic [KW-1:0] r_ky;
  logic [CW-1:0] r_c;
  logic          w_kx_wrap;
  logic          w_ky_wrap;
  logic          w_c_wrap;

  assign w_kx_wrap = (r_kx == KW'(K-1));
  assign w_ky_wrap = (r_ky == KW'(K-1));
  assign w_c_wrap  = (r_c  == CW'(CH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kx <= '0;
      r_ky <= '0;
      r_c  <= '0;
    end else if (i_advance) begin
      r_kx <= w_kx_wrap ? '0 : r_kx + 1'b1;
      if (w_kx_wrap) begin
        r_ky <= w_ky_wrap ? '0 : r_ky + 1'b1;
        if (w_ky_wrap) begin
          r_c <= w_c_wrap ? '0 : r_c + 1'b1;
        end
      end
    end
  end

  assign o_kx        = r_kx;
  assign o_ky        = r_ky;
  assign o_c         = r_c;
  assign o_first_tap = (r_kx == '0) && (r_ky == '0) && (r_c == '0);
  assign o_last_tap  = w_kx_wrap && w_ky_wrap && w_c_wrap;

endmodule
`default_nettype wire

// File: rtl/fire_ex3_seq.sv
`default_nettype none
// ============================================================================
// Module   : fire_ex3_seq
// Brief    : Stallable sequencer for the fire expand 3x3 MAC array: issues
//            IFM/weight reads per tap and hands finished pixels downstream.
// Options  : FIRE_SEQ_PERF_EN adds perf_cycles / perf_stall counters.
// Revision : 1.0
// ============================================================================
module fire_ex3_seq
  import fire_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fire_ex3_seq_if.slave      bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OXY_W-1:0]   r_ox;
  logic [OXY_W-1:0]   r_oy;
  logic [DRN_W-1:0]   r_drain;
  logic [MEM_LAT-1:0] r_en_pipe;
  logic [MEM_LAT-1:0] r_pad_pipe;
  logic [MEM_LAT-1:0] r_first_pipe;

  logic [KC_W-1:0]    w_kx;
  logic [KC_W-1:0]    w_ky;
  logic [CH_W-1:0]    w_c;
  logic               w_first_tap;
  logic               w_last_tap;
  logic               w_issue;
  logic               w_pix_adv;
  logic               w_last_pix;
  logic               w_inb;
  logic               w_rd;
  logic               w_busy;
  coord_t             w_iy;
  coord_t             w_ix;

  fire_tap_counter #(
    .K  (KERNEL_DIM),
    .CH (CHIN),
    .KW (KC_W),
    .CW (CH_W)
  ) u_taps (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_issue),
    .o_kx        (w_kx),
    .o_ky        (w_ky),
    .o_c         (w_c),
    .o_first_tap (w_first_tap),
    .o_last_tap  (w_last_tap)
  );

  assign w_last_pix = (r_ox == OXY_W'(W_OUT-1)) && (r_oy == OXY_W'(W_OUT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ox    <= '0;
      r_oy    <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
      if (w_pix_adv) begin
        if (r_ox == OXY_W'(W_OUT-1)) begin
          r_ox <= '0;
          r_oy <= (r_oy == OXY_W'(W_OUT-1)) ? '0 : r_oy + 1'b1;
        end else begin
          r_ox <= r_ox + 1'b1;
        end
      end
    end
  end

  // Issue only in RUN, so nothing can touch the accumulator while OUT waits.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pix_adv   = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_state_nxt = RUN;
      RUN: begin
        w_issue = 1'b1;
        if (w_last_tap) w_state_nxt = DRAIN;
      end
      DRAIN: if (r_drain == DRN_W'(MEM_LAT-1)) w_state_nxt = OUT;
      OUT: begin
        if (bus.ofm_ready) begin
          w_pix_adv   = 1'b1;
          w_state_nxt = w_last_pix ? DONE : RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_iy  = coord_t'(int'(r_oy)*STRIDE + int'(w_ky) - PAD);
  assign w_ix  = coord_t'(int'(r_ox)*STRIDE + int'(w_kx) - PAD);
  assign w_inb = in_bounds(w_iy) && in_bounds(w_ix);
  assign w_rd  = w_issue && w_inb;

  // MAC-side strobes follow the read data through the memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_pipe    <= '0;
      r_pad_pipe   <= '0;
      r_first_pipe <= '0;
    end else begin
      r_en_pipe[0]    <= w_issue;
      r_pad_pipe[0]   <= w_issue && !w_inb;
      r_first_pipe[0] <= w_issue && w_first_tap;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_en_pipe[i]    <= r_en_pipe[i-1];
        r_pad_pipe[i]   <= r_pad_pipe[i-1];
        r_first_pipe[i] <= r_first_pipe[i-1];
      end
    end
  end

  assign w_busy        = (r_state == RUN) || (r_state == DRAIN) || (r_state == OUT);
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == DONE);
  assign bus.ofm_valid = (r_state == OUT);
  assign bus.ofm_pix   = PIX_AW'(int'(r_oy)*W_OUT + int'(r_ox));
  assign bus.ifm_rd_en = w_rd;
  assign bus.ifm_addr  = w_rd ? IFM_AW'((int'(w_c)*W_IN + int'(w_iy))*W_IN + int'(w_ix)) : '0;
  assign bus.wgt_addr  = WGT_AW'(int'(w_c)*KERNEL_DIM*KERNEL_DIM + int'(w_ky)*KERNEL_DIM + int'(w_kx));
  assign bus.pad_zero  = r_pad_pipe[MEM_LAT-1];
  assign bus.mac_en    = r_en_pipe[MEM_LAT-1];
  assign bus.mac_first = r_first_pipe[MEM_LAT-1];

`ifdef FIRE_SEQ_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && bus.start)) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_busy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == OUT) && !bus.ofm_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire_ex3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_ex3_seq
// Brief    : Self-checking bench for fire_ex3_seq against a loop-level model.
// Revision : 1.0
// ============================================================================
module tb_fire_ex3_seq;
  import fire_seq_pkg::*;

  localparam int TAPS = CHIN*KERNEL_DIM*KERNEL_DIM;
  localparam int NPIX = W_OUT*W_OUT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fire_ex3_seq_if bus ();

  fire_ex3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         tot_stall;
  int         stall_len[NPIX];
  logic [2:0] dq[$];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] pack(input logic busy, input logic done, input logic rd,
                                       input logic [IFM_AW-1:0] addr, input logic [WGT_AW-1:0] wgt,
                                       input logic pad, input logic en, input logic first,
                                       input logic valid, input logic [PIX_AW-1:0] pix);
    return 64'({busy, done, rd, addr, wgt, pad, en, first, valid, pix});
  endfunction

  function automatic logic [63:0] observed(input logic mask_wgt);
    return pack(bus.busy, bus.done, bus.ifm_rd_en, bus.ifm_addr,
                mask_wgt ? WGT_AW'(0) : bus.wgt_addr, bus.pad_zero, bus.mac_en,
                bus.mac_first, bus.ofm_valid, bus.ofm_pix);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pipe_model();
    dq.delete();
    for (int i = 0; i < MEM_LAT; i++) dq.push_back(3'b000);
  endtask

  // One cycle of the reference: expected outputs for the tap (p,c,ky,kx) if
  // issuing, MAC strobes from MEM_LAT cycles ago, then drive inputs and advance.
  task automatic step(input string tag, input logic busy_e, input logic done_e, input logic iss,
                      input int p, input int c, input int ky, input int kx,
                      input logic valid_e, input int rdy_mode, input int st_mode);
    int         ox, oy, iy, ix, addr, wgt;
    logic       inb;
    logic [2:0] d;
    oy   = p / W_OUT;
    ox   = p % W_OUT;
    iy   = oy*STRIDE + ky - PAD;
    ix   = ox*STRIDE + kx - PAD;
    inb  = iss && (iy >= 0) && (iy < W_IN) && (ix >= 0) && (ix < W_IN);
    addr = inb ? (c*W_IN + iy)*W_IN + ix : 0;
    wgt  = iss ? c*KERNEL_DIM*KERNEL_DIM + ky*KERNEL_DIM + kx : 0;
    d    = dq.pop_front();
    dq.push_back(iss ? {1'b1, !inb, (c == 0 && ky == 0 && kx == 0)} : 3'b000);
    chk_eq(tag, observed(busy_e && !iss),
           pack(busy_e, done_e, inb, IFM_AW'(addr), WGT_AW'(wgt), d[1], d[2], d[0],
                valid_e, busy_e ? PIX_AW'(p) : PIX_AW'(0)));
    bus.start     = (st_mode < 0) ? (busy_e && ($urandom_range(0, 63) == 0)) : st_mode[0];
    bus.ofm_ready = (rdy_mode < 0) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    tot_stall     = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.ofm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_state", observed(1'b0), 64'd0);
`ifdef FIRE_SEQ_PERF_EN
    chk_eq("reset_perf_cycles", 64'(bus.perf_cycles), 64'd0);
    chk_eq("reset_perf_stall", 64'(bus.perf_stall), 64'd0);
`endif
    rst = 1'b0;
    reset_pipe_model();
    for (int p = 0; p < NPIX; p++) begin
      stall_len[p] = (p == 5) ? 20 : (($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      tot_stall += stall_len[p];
    end

    // Full layer: start at cycle 0, random ignored start/ready, stalls at OUT.
    cyc = 0;
    step("idle_start", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 1);
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < CHIN; c++)
        for (int ky = 0; ky < KERNEL_DIM; ky++)
          for (int kx = 0; kx < KERNEL_DIM; kx++) begin
            if (p == 0 && c == 0 && ky == 1 && kx == 1) begin
              chk_eq("p0_c0_t11_addr", 64'(bus.ifm_addr), 64'd0);
              chk_eq("p0_c0_t11_wgt", 64'(bus.wgt_addr), 64'd4);
            end
            if (p == 0 && c == 1 && ky == 2 && kx == 2) begin
              chk_eq("p0_c1_t22_addr", 64'(bus.ifm_addr), 64'd73);
              chk_eq("p0_c1_t22_wgt", 64'(bus.wgt_addr), 64'd17);
            end
            step("tap", 1'b1, 1'b0, 1'b1, p, c, ky, kx, 1'b0, -1, -1);
          end
      for (int d = 0; d < MEM_LAT; d++)
        step("drain", 1'b1, 1'b0, 1'b0, p, 0, 0, 0, 1'b0, -1, -1);
      for (int s = 0; s < stall_len[p]; s++)
        step("out_stall", 1'b1, 1'b0, 1'b0, p, 0, 0, 0, 1'b1, 0, -1);
      step("out_hs", 1'b1, 1'b0, 1'b0, p, 0, 0, 0, 1'b1, 1, -1);
    end
`ifdef FIRE_SEQ_PERF_EN
    chk_eq("perf_cycles", 64'(bus.perf_cycles), 64'(NPIX*(TAPS + MEM_LAT + 1) + tot_stall));
    chk_eq("perf_stall", 64'(bus.perf_stall), 64'(tot_stall));
`endif
    step("done", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, -1, 1);
    step("idle_after_done", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 0);
    step("idle_hold", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 0);

    // Synchronous reset mid-RUN, then a fresh layer restarts at pixel 0.
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.ofm_ready = 1'b1;
    repeat (2*(TAPS + MEM_LAT + 1) + 300) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("rst_midrun_outputs", observed(1'b0), 64'd0);
`ifdef FIRE_SEQ_PERF_EN
    chk_eq("rst_perf_cycles", 64'(bus.perf_cycles), 64'd0);
    chk_eq("rst_perf_stall", 64'(bus.perf_stall), 64'd0);
`endif
    reset_pipe_model();
    step("rst_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
    step("restart_go", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, -1, 1);
    for (int t = 0; t < 2*KERNEL_DIM*KERNEL_DIM; t++)
      step("restart_tap", 1'b1, 1'b0, 1'b1, 0, t/(KERNEL_DIM*KERNEL_DIM),
           (t/KERNEL_DIM) % KERNEL_DIM, t % KERNEL_DIM, 1'b0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
